shared_bus: RTL and testbench
=============================

# shared_bus

Shared system interconnect joining up to four bus masters (CPU instruction port, CPU data port, two spares) to eight memory-mapped slaves (ROM at slot 0, GPIO at slot 4, others spare). It holds a registered round-robin arbiter that picks one owning master. It multiplexes that master's address and control onto a single slave-side bus. It decodes the address into eight active-low chip selects and returns the selected slave's read data and ready to all masters.

## Interface
Parameters (from the shared package):
- WORD_ADDR_W, 30: word address width.
- WORD_DATA_W, 32: data width.
- SLAVE_IDX_MSB/LSB, 29/27: address bits selecting the slave.

Ports:
- clk  in  1  system clock.
- reset_  in  1  reset. One clock; reset is asynchronous and active-low.
- m0Req_..m3Req_  in  1 each  bus request, active-low.
- m0Grnt_..m3Grnt_  out  1 each  bus grant, active-low.
- m0Addr..m3Addr  in  WORD_ADDR_W each  master word address.
- m0As_..m3As_  in  1 each  address strobe, active-low.
- m0RW..m3RW  in  1 each  1 = read, 0 = write.
- m0Data..m3Data  in  WORD_DATA_W each  master write data.
- sAddr  out  WORD_ADDR_W  shared slave address.
- sAs_  out  1  shared slave strobe.
- sRW  out  1  shared slave read/write.
- sData  out  WORD_DATA_W  shared slave write data.
- s0CS_..s7CS_  out  1 each  slave chip selects, active-low.
- s0RdData..s7RdData  in  WORD_DATA_W each  slave read data.
- s0Rdy_..s7Rdy_  in  1 each  slave ready, active-low.
- mRdData  out  WORD_DATA_W  read data broadcast to all masters.
- mRdy_  out  1  ready broadcast to all masters.

## Operation
- Owner register (2 bits) names the current bus owner. Reset value 0, so m0Grnt_ = 0 and m1..m3Grnt_ = 1.
- Grants are decoded combinationally from the owner register. Exactly one grant is low at all times.
- Arbitration on each rising clk:
  - While the owner's Req_ is low, the owner is kept (no preemption).
  - When the owner's Req_ is high, requests are scanned round-robin starting at owner+1 (mod 4). The first master with Req_ low becomes owner.
  - If no master requests, the owner is unchanged (bus parked).
- Master mux: sAddr/sAs_/sRW/sData equal the owner's mAddr/mAs_/mRW/mData, combinationally.
  - A non-owner's signals never reach the slave bus.
- Address decode uses sAddr[29:27] = k and drives skCS_ = 0; all other CS_ are 1. Decode is independent of sAs_. Slaves qualify with As_ themselves.
  - Map: slot 0 ROM, 1 scratchpad, 2 timer, 3 UART, 4 GPIO, 5–7 reserved. Each slot spans 2^27 words.
- Read return: mRdData/mRdy_ equal s{k}RdData/s{k}Rdy_ for the selected k, combinationally. If no CS is active (unreachable), the default is mRdData = 0, mRdy_ = 1.
- Masters treat mRdy_ as valid only while they own the bus and have As_ low.

## Timing
- Grant latency: a request to an idle (parked, non-requesting-owner) bus is granted on the next rising clk. A master that already owns the bus has grant with zero latency.
- Simultaneous requests after release go to the nearest index after the old owner, wrapping 3→0.
- Release-to-regrant costs one cycle: Req_ high at edge N hands over at edge N.
- Slave path is fully combinational: sAddr→skCS_→skRdData→mRdData within one cycle. Slave wait states are expressed only through Rdy_.
- Asynchronous reset mid-transaction immediately forces owner = 0. The outputs then follow master 0's signals.

## Structure
- Shared package: word/data widths, slave-index bit range, slave slot numbers, ENABLE_/DISABLE_ polarity constants, READ/WRITE constants.
- Sub-module `bus_arbiter` holds the owner register and grant decode.
- The master mux, address decoder and slave mux stay combinational in the top level.

## Test plan
- Reset with m0..m3Req_ = 1. Required: m0Grnt_ = 0, others 1, s0CS_ = 0 (m0Addr = 0).
- m0 releases; m2Req_ and m3Req_ go low together. Required: m2Grnt_ = 0 after one edge. m2 holds for 5 cycles; m3 granted the edge after m2 releases.
- Owner 3 releases; m0 and m1 both request. Required: wrap-around grants m0.
- Owner m1 drives Addr = 0x2000_0000 (bits 29:27 = 4), As_ = 0, RW = 0, Data = 0x0000_00A5. Required:
  - s4CS_ = 0, other CS_ = 1.
  - sAddr/sData match m1's values.
  - mRdData passes s4RdData = 0x1234_5678.
- The same access with s4Rdy_ held 1 for 3 cycles. Required: mRdy_ stays 1 until s4Rdy_ = 0, then 0 in the same cycle.
- While m2 owns the bus, reset_ pulses low mid-cycle. Required: m0Grnt_ = 0 immediately, and sAddr tracks m0Addr.

Source files
------------

// File: rtl/shared_bus_pkg.sv
// Shared widths, slave slot map and bus polarity constants for the shared_bus interconnect.
package shared_bus_pkg;
  localparam int WORD_ADDR_W   = 30;
  localparam int WORD_DATA_W   = 32;
  localparam int SLAVE_IDX_MSB = 29;
  localparam int SLAVE_IDX_LSB = 27;
  localparam int NUM_MASTERS   = 4;
  localparam int NUM_SLAVES    = 8;

  localparam int SLOT_ROM     = 0;
  localparam int SLOT_SCRATCH = 1;
  localparam int SLOT_TIMER   = 2;
  localparam int SLOT_UART    = 3;
  localparam int SLOT_GPIO    = 4;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef logic [1:0] owner_t;
endpackage

// File: rtl/bus_arbiter.sv
// Registered round-robin owner select with combinational grant decode.
// Owner is held while it requests; handover happens on the edge its request drops.
module bus_arbiter
  import shared_bus_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_MASTERS-1:0] req_n_i,
  output logic [NUM_MASTERS-1:0] grnt_n_o,
  output owner_t                 owner_o
);
  owner_t owner_q, owner_d;
  owner_t cand;
  logic   found;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) owner_q <= '0;
    else         owner_q <= owner_d;
  end

  // Scan starts one past the owner so the last user gets lowest priority.
  always_comb begin
    owner_d = owner_q;
    cand    = owner_q;
    found   = 1'b0;
    if (req_n_i[owner_q] != ENABLE_) begin
      for (int i = 1; i < NUM_MASTERS; i++) begin
        cand = owner_q + owner_t'(i);
        if (!found && req_n_i[cand] == ENABLE_) begin
          owner_d = cand;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grnt_n_o          = {NUM_MASTERS{DISABLE_}};
    grnt_n_o[owner_q] = ENABLE_;
  end

  assign owner_o = owner_q;
endmodule

// File: rtl/shared_bus.sv
// Four-master, eight-slave shared bus: registered arbiter, combinational master mux,
// address decode and read-return mux; slave wait states pass straight through mRdy_.
module shared_bus
  import shared_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   m0Req_, m1Req_, m2Req_, m3Req_,
  output logic                   m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_,
  input  logic [WORD_ADDR_W-1:0] m0Addr, m1Addr, m2Addr, m3Addr,
  input  logic                   m0As_, m1As_, m2As_, m3As_,
  input  logic                   m0RW, m1RW, m2RW, m3RW,
  input  logic [WORD_DATA_W-1:0] m0Data, m1Data, m2Data, m3Data,
  output logic [WORD_ADDR_W-1:0] sAddr,
  output logic                   sAs_,
  output logic                   sRW,
  output logic [WORD_DATA_W-1:0] sData,
  output logic                   s0CS_, s1CS_, s2CS_, s3CS_, s4CS_, s5CS_, s6CS_, s7CS_,
  input  logic [WORD_DATA_W-1:0] s0RdData, s1RdData, s2RdData, s3RdData,
  input  logic [WORD_DATA_W-1:0] s4RdData, s5RdData, s6RdData, s7RdData,
  input  logic                   s0Rdy_, s1Rdy_, s2Rdy_, s3Rdy_, s4Rdy_, s5Rdy_, s6Rdy_, s7Rdy_,
  output logic [WORD_DATA_W-1:0] mRdData,
  output logic                   mRdy_
);
  logic [NUM_MASTERS-1:0] req_n, grnt_n;
  owner_t                 owner;
  logic [2:0]             slave_idx;
  logic [NUM_SLAVES-1:0]  cs_n, rdy_n;
  logic [WORD_DATA_W-1:0] rd_data [NUM_SLAVES];

  assign req_n = {m3Req_, m2Req_, m1Req_, m0Req_};

  bus_arbiter u_arbiter (
    .clk_i    (clk),
    .rst_ni   (reset_),
    .req_n_i  (req_n),
    .grnt_n_o (grnt_n),
    .owner_o  (owner)
  );

  assign {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_} = grnt_n;

  always_comb begin
    sAddr = m0Addr;
    sAs_  = m0As_;
    sRW   = m0RW;
    sData = m0Data;
    case (owner)
      2'd1: begin sAddr = m1Addr; sAs_ = m1As_; sRW = m1RW; sData = m1Data; end
      2'd2: begin sAddr = m2Addr; sAs_ = m2As_; sRW = m2RW; sData = m2Data; end
      2'd3: begin sAddr = m3Addr; sAs_ = m3As_; sRW = m3RW; sData = m3Data; end
      default: ;
    endcase
  end

  // Decode ignores sAs_; each slave qualifies its own select with the strobe.
  assign slave_idx = sAddr[SLAVE_IDX_MSB:SLAVE_IDX_LSB];
  assign cs_n      = ~(NUM_SLAVES'(1) << slave_idx);
  assign {s7CS_, s6CS_, s5CS_, s4CS_, s3CS_, s2CS_, s1CS_, s0CS_} = cs_n;

  assign rd_data[0] = s0RdData;
  assign rd_data[1] = s1RdData;
  assign rd_data[2] = s2RdData;
  assign rd_data[3] = s3RdData;
  assign rd_data[4] = s4RdData;
  assign rd_data[5] = s5RdData;
  assign rd_data[6] = s6RdData;
  assign rd_data[7] = s7RdData;
  assign rdy_n = {s7Rdy_, s6Rdy_, s5Rdy_, s4Rdy_, s3Rdy_, s2Rdy_, s1Rdy_, s0Rdy_};

  always_comb begin
    mRdData = '0;
    mRdy_   = DISABLE_;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (cs_n[k] == ENABLE_) begin
        mRdData = rd_data[k];
        mRdy_   = rdy_n[k];
      end
    end
  end
endmodule

// File: tb/tb_shared_bus.sv
// Randomized self-checking bench for shared_bus against a round-robin ownership model.
module tb_shared_bus;
  import shared_bus_pkg::*;

  logic clk = 1'b0;
  logic reset_;
  logic [3:0]             req_n;
  logic [WORD_ADDR_W-1:0] m_addr [4];
  logic [3:0]             m_as_n, m_rw;
  logic [WORD_DATA_W-1:0] m_data [4];
  logic [WORD_DATA_W-1:0] s_rd [8];
  logic [7:0]             s_rdy_n;

  logic m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_;
  logic [WORD_ADDR_W-1:0] sAddr;
  logic sAs_, sRW;
  logic [WORD_DATA_W-1:0] sData, mRdData;
  logic s0CS_, s1CS_, s2CS_, s3CS_, s4CS_, s5CS_, s6CS_, s7CS_;
  logic mRdy_;

  int checks = 0;
  int failures = 0;
  int model_owner = 0;

  logic [3:0] grnt_obs;
  logic [7:0] cs_obs;
  assign grnt_obs = {m3Grnt_, m2Grnt_, m1Grnt_, m0Grnt_};
  assign cs_obs   = {s7CS_, s6CS_, s5CS_, s4CS_, s3CS_, s2CS_, s1CS_, s0CS_};

  always #5 clk = ~clk;

  shared_bus dut (
    .clk(clk), .reset_(reset_),
    .m0Req_(req_n[0]), .m1Req_(req_n[1]), .m2Req_(req_n[2]), .m3Req_(req_n[3]),
    .m0Grnt_(m0Grnt_), .m1Grnt_(m1Grnt_), .m2Grnt_(m2Grnt_), .m3Grnt_(m3Grnt_),
    .m0Addr(m_addr[0]), .m1Addr(m_addr[1]), .m2Addr(m_addr[2]), .m3Addr(m_addr[3]),
    .m0As_(m_as_n[0]), .m1As_(m_as_n[1]), .m2As_(m_as_n[2]), .m3As_(m_as_n[3]),
    .m0RW(m_rw[0]), .m1RW(m_rw[1]), .m2RW(m_rw[2]), .m3RW(m_rw[3]),
    .m0Data(m_data[0]), .m1Data(m_data[1]), .m2Data(m_data[2]), .m3Data(m_data[3]),
    .sAddr(sAddr), .sAs_(sAs_), .sRW(sRW), .sData(sData),
    .s0CS_(s0CS_), .s1CS_(s1CS_), .s2CS_(s2CS_), .s3CS_(s3CS_),
    .s4CS_(s4CS_), .s5CS_(s5CS_), .s6CS_(s6CS_), .s7CS_(s7CS_),
    .s0RdData(s_rd[0]), .s1RdData(s_rd[1]), .s2RdData(s_rd[2]), .s3RdData(s_rd[3]),
    .s4RdData(s_rd[4]), .s5RdData(s_rd[5]), .s6RdData(s_rd[6]), .s7RdData(s_rd[7]),
    .s0Rdy_(s_rdy_n[0]), .s1Rdy_(s_rdy_n[1]), .s2Rdy_(s_rdy_n[2]), .s3Rdy_(s_rdy_n[3]),
    .s4Rdy_(s_rdy_n[4]), .s5Rdy_(s_rdy_n[5]), .s6Rdy_(s_rdy_n[6]), .s7Rdy_(s_rdy_n[7]),
    .mRdData(mRdData), .mRdy_(mRdy_)
  );

  // Owner keeps the bus while requesting; otherwise the nearest requester after it wins.
  function automatic int next_owner(input int cur, input logic [3:0] req);
    if (req[cur] == 1'b0) return cur;
    for (int i = 1; i < 4; i++)
      if (req[(cur + i) % 4] == 1'b0) return (cur + i) % 4;
    return cur;
  endfunction

  function automatic logic [3:0] exp_grants(input int own);
    logic [3:0] g = 4'b1111;
    g[own] = 1'b0;
    return g;
  endfunction

  function automatic logic [7:0] exp_cs(input logic [WORD_ADDR_W-1:0] a);
    logic [7:0] c = 8'hFF;
    c[a / (1 << 27)] = 1'b0;
    return c;
  endfunction

  task automatic tick();
    int nxt;
    nxt = next_owner(model_owner, req_n);
    @(posedge clk);
    #1;
    model_owner = nxt;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    req_n = 4'hF;
    m_as_n = 4'hF;
    m_rw = 4'hF;
    s_rdy_n = 8'hFF;
    for (int i = 0; i < 4; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    for (int k = 0; k < 8; k++) s_rd[k] = $urandom;
    #2;
    checks++;
    if (grnt_obs !== 4'b1110) begin
      failures++; $display("FAIL reset_grants got=%b want=1110", grnt_obs);
    end
    checks++;
    if (cs_obs !== 8'hFE) begin
      failures++; $display("FAIL reset_cs got=%b want=11111110", cs_obs);
    end
    @(negedge clk);
    reset_ = 1'b1;
    model_owner = 0;
    tick();
    checks++;
    if (grnt_obs !== 4'b1110) begin
      failures++; $display("FAIL parked_grants got=%b want=1110", grnt_obs);
    end
  endtask

  task automatic test_rr_handover();
    @(negedge clk);
    req_n = 4'b0011;
    tick();
    checks++;
    if (grnt_obs !== 4'b1011) begin
      failures++; $display("FAIL grant_m2 got=%b want=1011", grnt_obs);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (grnt_obs !== 4'b1011) begin
        failures++; $display("FAIL hold_m2 cyc=%0d got=%b want=1011", c, grnt_obs);
      end
    end
    @(negedge clk);
    req_n = 4'b0111;
    tick();
    checks++;
    if (grnt_obs !== 4'b0111) begin
      failures++; $display("FAIL grant_m3 got=%b want=0111", grnt_obs);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    req_n = 4'b1100;
    tick();
    checks++;
    if (grnt_obs !== 4'b1110) begin
      failures++; $display("FAIL wrap_m0 got=%b want=1110", grnt_obs);
    end
    @(negedge clk);
    req_n = 4'b1101;
    tick();
    checks++;
    if (grnt_obs !== 4'b1101) begin
      failures++; $display("FAIL grant_m1 got=%b want=1101", grnt_obs);
    end
  endtask

  task automatic test_decode_and_wait();
    @(negedge clk);
    m_addr[1] = 30'h2000_0000;
    m_as_n[1] = 1'b0;
    m_rw[1] = WRITE;
    m_data[1] = 32'h0000_00A5;
    s_rd[4] = 32'h1234_5678;
    s_rdy_n[4] = 1'b0;
    #1;
    checks++;
    if (cs_obs !== 8'b1110_1111) begin
      failures++; $display("FAIL gpio_cs got=%b want=11101111", cs_obs);
    end
    checks++;
    if (sAddr !== 30'h2000_0000 || sData !== 32'h0000_00A5 || sAs_ !== 1'b0 || sRW !== 1'b0) begin
      failures++; $display("FAIL m1_mux got addr=%h data=%h as=%b rw=%b want 20000000/000000a5/0/0",
                           sAddr, sData, sAs_, sRW);
    end
    checks++;
    if (mRdData !== 32'h1234_5678 || mRdy_ !== 1'b0) begin
      failures++; $display("FAIL gpio_rd got=%h rdy=%b want=12345678 rdy=0", mRdData, mRdy_);
    end
    s_rdy_n[4] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (mRdy_ !== 1'b1) begin
        failures++; $display("FAIL wait_state cyc=%0d got=%b want=1", c, mRdy_);
      end
    end
    @(negedge clk);
    s_rdy_n[4] = 1'b0;
    #1;
    checks++;
    if (mRdy_ !== 1'b0) begin
      failures++; $display("FAIL ready_release got=%b want=0", mRdy_);
    end
  endtask

  task automatic test_random();
    logic [WORD_ADDR_W-1:0] ea;
    logic [7:0] ecs;
    int sel;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      req_n = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_n = 4'hF;
      for (int i = 0; i < 4; i++) begin
        m_addr[i] = 30'($urandom);
        m_data[i] = $urandom;
      end
      m_as_n = 4'($urandom);
      m_rw = 4'($urandom);
      for (int k = 0; k < 8; k++) s_rd[k] = $urandom;
      s_rdy_n = 8'($urandom);
      #1;
      ea = m_addr[model_owner];
      ecs = exp_cs(ea);
      sel = int'(ea / (1 << 27));
      checks++;
      if (grnt_obs !== exp_grants(model_owner)) begin
        failures++; $display("FAIL rnd_grant it=%0d got=%b want=%b", it, grnt_obs, exp_grants(model_owner));
      end
      checks++;
      if (sAddr !== ea || sData !== m_data[model_owner] || sAs_ !== m_as_n[model_owner] ||
          sRW !== m_rw[model_owner]) begin
        failures++; $display("FAIL rnd_mux it=%0d got addr=%h data=%h want addr=%h data=%h",
                             it, sAddr, sData, ea, m_data[model_owner]);
      end
      checks++;
      if (cs_obs !== ecs) begin
        failures++; $display("FAIL rnd_cs it=%0d got=%b want=%b", it, cs_obs, ecs);
      end
      checks++;
      if (mRdData !== s_rd[sel] || mRdy_ !== s_rdy_n[sel]) begin
        failures++; $display("FAIL rnd_rd it=%0d got=%h/%b want=%h/%b", it, mRdData, mRdy_,
                             s_rd[sel], s_rdy_n[sel]);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_n = 4'b1011;
    tick();
    checks++;
    if (grnt_obs !== 4'b1011) begin
      failures++; $display("FAIL pre_reset_m2 got=%b want=1011", grnt_obs);
    end
    #2;
    reset_ = 1'b0;
    #1;
    model_owner = 0;
    checks++;
    if (grnt_obs !== 4'b1110) begin
      failures++; $display("FAIL async_grant got=%b want=1110", grnt_obs);
    end
    checks++;
    if (sAddr !== m_addr[0]) begin
      failures++; $display("FAIL async_addr got=%h want=%h", sAddr, m_addr[0]);
    end
    m_addr[0] = 30'h1555_AAAA;
    #1;
    checks++;
    if (sAddr !== 30'h1555_AAAA) begin
      failures++; $display("FAIL async_track got=%h want=1555aaaa", sAddr);
    end
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rr_handover();
    test_wrap();
    test_decode_and_wait();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
